// File: rtl/mux_sel_arbiter8_pkg.sv
// Shared widths, FSM encoding and helpers for the 8-way round-robin selector arbiter.
package mux_sel_arbiter8_pkg;

   localparam int NUM_REQ = 8;
   localparam int IDX_W   = 3;
   localparam int SEL_W   = 8;
   localparam int CNT_W   = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } arb_state_e;

   function automatic logic [NUM_REQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
      return NUM_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/mux_sel_arbiter8_rr_pick8.sv
// Rotating first-set finder: returns the first requester at or after ptr_i, wrapping mod 8.
module rr_pick8
   import mux_sel_arbiter8_pkg::*;
(
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic               found_o,
   output logic [IDX_W-1:0]   idx_o
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      cand    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = ptr_i + IDX_W'(k);
         if (!found_o && req_i[cand]) begin
            found_o = 1'b1;
            idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/mux_sel_arbiter8.sv
// Round-robin owner arbitration for the shared 8:1 byte mux, with a hold timeout when others wait.
// state | meaning
// IDLE  | no owner; arbitrate from ptr_q this cycle
// OWNED | grant held by sel_q until rel, request drop, or hold timeout
module mux_sel_arbiter8
   import mux_sel_arbiter8_pkg::*;
#(
   parameter int    UUID     = 0,
   parameter string NAME     = "",
   parameter int    MAX_HOLD = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               rel,
   output logic [NUM_REQ-1:0] grant,
   output logic [SEL_W-1:0]   Selector,
   output logic               busy,
   output logic               timeout
);

   if (MAX_HOLD < 0 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("mux_sel_arbiter8 %s (uuid %0d): MAX_HOLD %0d outside 0..255", NAME, UUID, MAX_HOLD);
   end

   localparam logic             HOLD_EN   = (MAX_HOLD != 0);
   localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : '0;

   arb_state_e         state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]   sel_q, sel_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               timeout_q, timeout_d;

   logic               pick_found;
   logic [IDX_W-1:0]   pick_idx;
   logic               rel_own;
   logic               hold_hit;
   logic               others_wait;
   logic               rel_force;

   rr_pick8 u_pick (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   assign rel_own     = rel | ~req[sel_q];
   assign hold_hit    = HOLD_EN && (cnt_q == HOLD_LAST);
   assign others_wait = |(req & ~grant_q);
   assign rel_force   = hold_hit & others_wait;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      sel_d     = sel_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = OWNED;
               grant_d = onehot8(pick_idx);
               sel_d   = pick_idx;
               cnt_d   = '0;
            end
         end
         OWNED: begin
            // Selector deliberately keeps the last owner so the mux input does not move on release.
            if (rel_own || rel_force) begin
               state_d   = IDLE;
               grant_d   = '0;
               ptr_d     = sel_q + IDX_W'(1);
               timeout_d = rel_force & ~rel_own;
            end else if (HOLD_EN && !hold_hit) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         sel_q     <= '0;
         ptr_q     <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         sel_q     <= sel_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign grant    = grant_q;
   assign Selector = {{(SEL_W-IDX_W){1'b0}}, sel_q};
   assign busy     = (state_q == OWNED);
   assign timeout  = timeout_q;

endmodule

// File: tb/tb_mux_sel_arbiter8.sv
// Scoreboard bench: two arbiters (MAX_HOLD 16 and 4) driven cycle by cycle against hand-derived expectations.
module tb_mux_sel_arbiter8;

   typedef struct {
      string      tag;
      int         which;
      logic [7:0] grant;
      logic [7:0] sel;
      logic       busy;
      logic       to;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [7:0] req_a, req_b;
   logic       rel_a, rel_b;
   logic [7:0] grant_a, grant_b, sel_a, sel_b;
   logic       busy_a, busy_b, to_a, to_b;

   exp_t       sb_q[$];
   int         n_cmp;
   int         n_bad;

   mux_sel_arbiter8 #(.UUID(1), .NAME("arb_a"), .MAX_HOLD(16)) u_dut_a (
      .clk      (clk),
      .rst      (rst),
      .req      (req_a),
      .rel      (rel_a),
      .grant    (grant_a),
      .Selector (sel_a),
      .busy     (busy_a),
      .timeout  (to_a)
   );

   mux_sel_arbiter8 #(.UUID(2), .NAME("arb_b"), .MAX_HOLD(4)) u_dut_b (
      .clk      (clk),
      .rst      (rst),
      .req      (req_b),
      .rel      (rel_b),
      .grant    (grant_b),
      .Selector (sel_b),
      .busy     (busy_b),
      .timeout  (to_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, queue what the outputs must be after the next edge, then compare.
   task automatic step(input int which, input logic [7:0] rq, input logic rl,
                       input logic [7:0] eg, input logic [7:0] es, input logic eb,
                       input logic et, input string tag);
      exp_t e;
      exp_t got;
      if (which == 0) begin
         req_a = rq;
         rel_a = rl;
      end else begin
         req_b = rq;
         rel_b = rl;
      end
      e.tag = tag; e.which = which; e.grant = eg; e.sel = es; e.busy = eb; e.to = et;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      if (got.which == 0) begin
         check_val({got.tag, ".grant"}, 32'(grant_a), 32'(got.grant));
         check_val({got.tag, ".sel"},   32'(sel_a),   32'(got.sel));
         check_val({got.tag, ".busy"},  32'(busy_a),  32'(got.busy));
         check_val({got.tag, ".to"},    32'(to_a),    32'(got.to));
      end else begin
         check_val({got.tag, ".grant"}, 32'(grant_b), 32'(got.grant));
         check_val({got.tag, ".sel"},   32'(sel_b),   32'(got.sel));
         check_val({got.tag, ".busy"},  32'(busy_b),  32'(got.busy));
         check_val({got.tag, ".to"},    32'(to_b),    32'(got.to));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] one;
      int         nxt;
      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b0;
      req_a = 8'h00; rel_a = 1'b0;
      req_b = 8'h00; rel_b = 1'b0;
      #12;
      check_val("por.grant", 32'(grant_a), 32'h0);
      check_val("por.sel",   32'(sel_a),   32'h0);
      check_val("por.busy",  32'(busy_a),  32'h0);
      check_val("por.to",    32'(to_a),    32'h0);
      rst = 1'b1;

      // Basic grant/release from reset (ptr=0): 2 wins, then 5 after the bubble.
      step(0, 8'h24, 1'b0, 8'h04, 8'd2, 1'b1, 1'b0, "basic_g2");
      step(0, 8'h24, 1'b1, 8'h00, 8'd2, 1'b0, 1'b0, "basic_rel");
      step(0, 8'h24, 1'b0, 8'h20, 8'd5, 1'b1, 1'b0, "basic_g5");
      step(0, 8'h00, 1'b0, 8'h00, 8'd5, 1'b0, 1'b0, "drop5");

      // ptr=6 now; take a grant, then reset asynchronously mid-cycle with req=0xFF.
      step(0, 8'hFF, 1'b0, 8'h40, 8'd6, 1'b1, 1'b0, "pre_rst_g6");
      #2 rst = 1'b0;
      #1;
      check_val("async_rst.grant", 32'(grant_a), 32'h0);
      check_val("async_rst.sel",   32'(sel_a),   32'h0);
      check_val("async_rst.busy",  32'(busy_a),  32'h0);
      check_val("async_rst.to",    32'(to_a),    32'h0);
      rst = 1'b1;

      step(0, 8'h81, 1'b0, 8'h01, 8'd0, 1'b1, 1'b0, "post_rst_g0");
      step(0, 8'h81, 1'b1, 8'h00, 8'd0, 1'b0, 1'b0, "post_rst_rel");
      step(0, 8'h81, 1'b0, 8'h80, 8'd7, 1'b1, 1'b0, "wrap_g7");
      step(0, 8'h81, 1'b1, 8'h00, 8'd7, 1'b0, 1'b0, "wrap_rel");

      // Round robin with everyone requesting and rel pulsed in each owned cycle.
      step(0, 8'hFF, 1'b0, 8'h01, 8'd0, 1'b1, 1'b0, "rr_g0");
      for (int k = 0; k < 9; k++) begin
         nxt = (k + 1) % 8;
         one = 8'h01 << nxt;
         step(0, 8'hFF, 1'b1, 8'h00, 8'(k % 8), 1'b0, 1'b0, "rr_rel");
         step(0, 8'hFF, 1'b0, one, 8'(nxt), 1'b1, 1'b0, "rr_grant");
      end

      // Owner 3: drop its request and assert rel together; next pick starts at 4.
      step(0, 8'h18, 1'b1, 8'h00, 8'd1, 1'b0, 1'b0, "o3_pre_rel");
      step(0, 8'h18, 1'b0, 8'h08, 8'd3, 1'b1, 1'b0, "o3_g3");
      step(0, 8'h18, 1'b0, 8'h08, 8'd3, 1'b1, 1'b0, "o3_hold");
      step(0, 8'h10, 1'b1, 8'h00, 8'd3, 1'b0, 1'b0, "o3_drop_rel");
      step(0, 8'h11, 1'b0, 8'h10, 8'd4, 1'b1, 1'b0, "o3_next_g4");
      step(0, 8'h00, 1'b0, 8'h00, 8'd4, 1'b0, 1'b0, "a_done");

      // MAX_HOLD=4: forced release after exactly 4 owned cycles.
      step(1, 8'h03, 1'b0, 8'h01, 8'd0, 1'b1, 1'b0, "to_c0");
      for (int k = 1; k < 4; k++)
         step(1, 8'h03, 1'b0, 8'h01, 8'd0, 1'b1, 1'b0, "to_hold");
      step(1, 8'h03, 1'b0, 8'h00, 8'd0, 1'b0, 1'b1, "to_force");
      step(1, 8'h03, 1'b0, 8'h02, 8'd1, 1'b1, 1'b0, "to_next_g1");
      step(1, 8'h00, 1'b0, 8'h00, 8'd1, 1'b0, 1'b0, "to_drop");

      // Uncontended owner keeps the grant well past MAX_HOLD.
      step(1, 8'h01, 1'b0, 8'h01, 8'd0, 1'b1, 1'b0, "unc_g0");
      for (int k = 0; k < 20; k++)
         step(1, 8'h01, 1'b0, 8'h01, 8'd0, 1'b1, 1'b0, "unc_hold");

      // Saturated counter plus a new waiter plus rel: release without timeout.
      step(1, 8'h03, 1'b1, 8'h00, 8'd0, 1'b0, 1'b0, "rel_and_c");
      step(1, 8'h03, 1'b0, 8'h02, 8'd1, 1'b1, 1'b0, "rel_and_c_g1");
      step(1, 8'h00, 1'b0, 8'h00, 8'd1, 1'b0, 1'b0, "b_done");

      if (sb_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mux_sel_arbiter8.md
Name: mux_sel_arbiter8

Overview:
- Round-robin arbiter that shares one 8-input, 8-bit selector mux (one shared byte bus) between 8 requesters.
- Produces the mux Selector byte and a one-hot grant. Grants are held until the owner releases, or until a hold timeout expires while others are waiting.
- Sits in front of the shared output/operand bus of the LEG core; requesters are bus sources (register read ports, I/O, call/return stack).

Parameters:
- UUID, 0, instance identifier (XOR-combined into sub-instances as elsewhere in the design).
- NAME, "", instance name string.
- MAX_HOLD, 16, maximum consecutive grant cycles while another requester waits. Range 0..255; 0 disables the timeout.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-low.
- req  input  8  request vector, bit i = requester i.
- rel  input  1  release strobe from the current owner.
- grant  output  8  one-hot grant, or 0 when no owner.
- Selector  output  8  zero-extended index of the current/last owner; drives the mux Selector.
- busy  output  1  high while a grant is held.
- timeout  output  1  one-cycle pulse after a forced release.

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous): state=IDLE, grant=0, Selector=0, busy=0, timeout=0, round-robin pointer ptr=0, hold counter cnt=0. Outputs clear immediately without waiting for a clock edge.
- States:
  - IDLE: no owner.
  - OWNED: grant held.
- IDLE arbitration:
  - If req!=0, pick the first set bit scanning ptr, ptr+1, ... mod 8.
  - Next edge: grant=one-hot(winner), Selector=winner, busy=1, cnt=0, state=OWNED.
  - Request-to-grant latency is 1 cycle.
  - If req==0, stay in IDLE.
- OWNED release conditions, evaluated each cycle:
  - (a) rel=1
  - (b) req[owner]=0
  - (c) MAX_HOLD!=0 and cnt==MAX_HOLD-1 and (req & ~grant)!=0
- On any release condition:
  - Next edge: grant=0, busy=0, ptr=(owner+1) mod 8, state=IDLE.
  - Selector keeps its value (mux input unchanged, no glitch).
- Handover bubble: every release is followed by exactly one IDLE cycle. Consecutive grants to different requesters are therefore spaced 2 cycles apart.
- timeout:
  - Set to 1 on the release edge only when condition (c) alone caused the release.
  - If (a) or (b) holds in the same cycle, timeout=0.
  - Cleared on the next edge.
- cnt:
  - Increments every OWNED cycle.
  - Saturates at MAX_HOLD-1 when no other requester waits, so an uncontended owner keeps the grant indefinitely.
  - 8 bits wide; no wrap.
  - When MAX_HOLD=0, cnt is held at 0.
- Owner fairness: a forced-out owner may be re-granted only after all other requesters that were set in req at arbitration time, because ptr advances past it.
- Requests arriving or dropping for non-owners during OWNED have no effect until the next IDLE cycle.
- grant is always one-hot or zero. Selector[7:3] is always 0.

Decomposition:
- Shared package:
  - NUM_REQ=8, IDX_W=3, SEL_W=8, CNT_W=8.
  - State encoding IDLE=1'b0, OWNED=1'b1.
  - Function onehot8(idx).
- One sub-module: rr_pick8, combinational rotating first-set finder.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: found, idx[2:0].
  - Keeps the arbiter FSM file free of the scan logic.

Test Plan:
- Reset: drive rst=0 mid-cycle with req=0xFF -> grant=0, Selector=0, busy=0, timeout=0 immediately, with no clock edge needed.
- Basic grant/release, MAX_HOLD=16:
  - req=0x24 from reset -> 1 cycle later grant=0x04, Selector=2, busy=1.
  - rel=1 for one cycle -> next cycle grant=0; following cycle grant=0x20, Selector=5.
- Round-robin: req=0xFF held, rel pulsed in every OWNED cycle -> Selector sequence 0,1,2,...,7,0, each grant 1 cycle long, separated by 1-cycle bubbles.
- Forced timeout, MAX_HOLD=4: req=0x03, rel never asserted -> grant=0x01 for exactly 4 cycles, then grant=0 with timeout=1 for 1 cycle, then grant=0x02, Selector=1.
- Uncontended hold, MAX_HOLD=4: req=0x01 only for 20 cycles -> grant stays 0x01 throughout, timeout never asserted.
- Owner drop and simultaneous events:
  - While owner 3 is held, drop req[3] and assert rel in the same cycle -> release with timeout=0, next owner found from ptr=4.
  - Reset mid-grant, then req=0x81 after rst deasserts -> grant=0x01 (ptr restarted at 0).
